// File: rtl/branch_target_buffer_if.sv
// Fetch/execute-side bus of the branch target buffer: EXE training inputs,
// IF lookup key and the combinational prediction.
interface branch_target_buffer_if #(
  parameter int AW = 12
);
  logic [AW-1:0] insert_ins_addr;
  logic [AW-1:0] insert_ins_next_addr;
  logic          is_branch;
  logic          is_suc;
  logic [AW-1:0] query_ins_addr;
  logic [AW-1:0] predict_addr;
  logic          predict_jump;

  modport master (
    output insert_ins_addr, insert_ins_next_addr, is_branch, is_suc, query_ins_addr,
    input  predict_addr, predict_jump
  );

  modport slave (
    input  insert_ins_addr, insert_ins_next_addr, is_branch, is_suc, query_ins_addr,
    output predict_addr, predict_jump
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Fully associative BTB with 2-bit saturating counters: zero-latency lookup
// keyed by fetch PC+4, registered training from resolved EXE branches/jumps.
module branch_target_buffer #(
  parameter int ENTRIES = 8,
  parameter int AW      = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_target_buffer_if.slave bus
);
  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0]             valid;
  logic [ENTRIES-1:0][AW-1:0]     tag;
  logic [ENTRIES-1:0][AW-1:0]     target;
  logic [ENTRIES-1:0][1:0]        cnt;
  logic [PW-1:0]                  ptr;

  logic [ENTRIES-1:0]             q_hit;
  logic [ENTRIES-1:0]             u_hit;
  logic                           free_found;
  logic [PW-1:0]                  free_idx;
  logic [PW-1:0]                  victim;
  logic                           pj;
  logic [AW-1:0]                  pa;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    assign q_hit[i] = valid[i] && (tag[i] == bus.query_ins_addr);
    assign u_hit[i] = valid[i] && (tag[i] == bus.insert_ins_addr);
  end

  // Tags are unique, so at most one q_hit bit is set and the loop is a plain mux.
  always_comb begin
    pj = 1'b0;
    pa = bus.query_ins_addr;
    for (int i = 0; i < ENTRIES; i++) begin
      if (q_hit[i] && cnt[i][1]) begin
        pj = 1'b1;
        pa = target[i];
      end
    end
  end

  assign bus.predict_jump = pj;
  assign bus.predict_addr = pa;

  // Lowest-index invalid entry wins; scanning downward leaves the lowest in free_idx.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = PW'(i);
      end
    end
    victim = free_found ? free_idx : ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      ptr   <= '0;
    end else if (bus.is_branch) begin
      if (|u_hit) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (u_hit[i]) begin
            if (bus.is_suc) begin
              cnt[i]    <= (cnt[i] == 2'd3) ? 2'd3 : cnt[i] + 2'd1;
              target[i] <= bus.insert_ins_next_addr;
            end else begin
              cnt[i]    <= (cnt[i] == 2'd0) ? 2'd0 : cnt[i] - 2'd1;
            end
          end
        end
      end else if (bus.is_suc) begin
        valid[victim]  <= 1'b1;
        tag[victim]    <= bus.insert_ins_addr;
        target[victim] <= bus.insert_ins_next_addr;
        cnt[victim]    <= 2'b10;
        // Round-robin pointer only advances when a live entry is evicted.
        if (!free_found) ptr <= ptr + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed plan plus random traffic
// against a FIFO/associative-array reference model.
module tb_branch_target_buffer;
  localparam int ENTRIES = 8;
  localparam int AW      = 12;

  typedef struct {
    logic          pj;
    logic [AW-1:0] pa;
    logic [AW-1:0] qa;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  exp_t exp_q[$];

  // Reference model: residency in insertion order (oldest evicted first), plus per-key state.
  logic [AW-1:0] fifo[$];
  int            cnt_m[logic [AW-1:0]];
  logic [AW-1:0] tgt_m[logic [AW-1:0]];

  branch_target_buffer_if #(.AW(AW)) bus ();

  branch_target_buffer #(.ENTRIES(ENTRIES), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (bus.predict_jump !== e.pj || bus.predict_addr !== e.pa) begin
        errors++;
        $display("FAIL predict q=%h: got jump=%0b addr=%h, expected jump=%0b addr=%h",
                 e.qa, bus.predict_jump, bus.predict_addr, e.pj, e.pa);
      end
    end
  end

  task automatic model_update(input logic r, input logic ib, input logic suc,
                              input logic [AW-1:0] ia, input logic [AW-1:0] na);
    if (r) begin
      fifo.delete();
      cnt_m.delete();
      tgt_m.delete();
    end else if (ib) begin
      if (cnt_m.exists(ia)) begin
        if (suc) begin
          cnt_m[ia] = (cnt_m[ia] + 1 > 3) ? 3 : cnt_m[ia] + 1;
          tgt_m[ia] = na;
        end else begin
          cnt_m[ia] = (cnt_m[ia] - 1 < 0) ? 0 : cnt_m[ia] - 1;
        end
      end else if (suc) begin
        if (fifo.size() == ENTRIES) begin
          logic [AW-1:0] old;
          old = fifo.pop_front();
          cnt_m.delete(old);
          tgt_m.delete(old);
        end
        fifo.push_back(ia);
        cnt_m[ia] = 2;
        tgt_m[ia] = na;
      end
    end
  endtask

  // One clock cycle: inputs applied now, expected output (pre-edge state) queued,
  // model advanced to the post-edge state.
  task automatic cyc(input logic r, input logic ib, input logic suc,
                     input logic [AW-1:0] ia, input logic [AW-1:0] na,
                     input logic [AW-1:0] qa, input bit chk);
    exp_t e;
    rst = r;
    bus.is_branch = ib;
    bus.is_suc = suc;
    bus.insert_ins_addr = ia;
    bus.insert_ins_next_addr = na;
    bus.query_ins_addr = qa;
    if (chk) begin
      e.qa = qa;
      if (cnt_m.exists(qa) && cnt_m[qa] >= 2) begin
        e.pj = 1'b1;
        e.pa = tgt_m[qa];
      end else begin
        e.pj = 1'b0;
        e.pa = qa;
      end
      exp_q.push_back(e);
    end
    model_update(r, ib, suc, ia, na);
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic suc, input logic [AW-1:0] ia, input logic [AW-1:0] na);
    cyc(1'b0, 1'b1, suc, ia, na, ia, 1'b1);
  endtask

  task automatic qry(input logic [AW-1:0] qa);
    cyc(1'b0, 1'b0, 1'b0, '0, '0, qa, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.is_branch = 1'b0;
    bus.is_suc = 1'b0;
    bus.insert_ins_addr = '0;
    bus.insert_ins_next_addr = '0;
    bus.query_ins_addr = '0;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);

    // Basic training and counter walk on 0x014
    qry(12'h014);
    upd(1'b1, 12'h014, 12'h040);
    qry(12'h014);
    upd(1'b0, 12'h014, 12'h000);
    qry(12'h014);
    upd(1'b0, 12'h014, 12'h000);
    qry(12'h014);
    upd(1'b1, 12'h014, 12'h080);
    qry(12'h014);
    upd(1'b1, 12'h014, 12'h080);
    qry(12'h014);

    // Saturation on 0x020
    for (int i = 0; i < 5; i++) upd(1'b1, 12'h020, 12'h0C0);
    upd(1'b0, 12'h020, 12'h000);
    qry(12'h020);
    upd(1'b0, 12'h020, 12'h000);
    qry(12'h020);

    // Not-taken on absent key does not allocate
    upd(1'b0, 12'h100, 12'h200);
    qry(12'h100);

    // Capacity and round-robin eviction from a clean table
    cyc(1'b1, 1'b0, 1'b0, '0, '0, 12'h014, 1'b1);
    for (int k = 1; k <= 9; k++) upd(1'b1, AW'(k * 4), AW'(12'h400 + k * 16));
    qry(12'h004);
    qry(12'h024);
    qry(12'h008);
    upd(1'b1, 12'h028, 12'h500);
    qry(12'h008);
    qry(12'h00C);
    qry(12'h028);

    // Same-edge query/update: old state now, new state next cycle
    cyc(1'b0, 1'b1, 1'b1, 12'h030, 12'h600, 12'h030, 1'b1);
    qry(12'h030);

    // Reset wins over a simultaneous update
    cyc(1'b1, 1'b1, 1'b1, 12'h034, 12'h700, 12'h030, 1'b1);
    qry(12'h034);
    qry(12'h030);
    qry(12'h028);

    // Random traffic over a small key pool so hits, saturation and eviction all occur
    for (int n = 0; n < 2000; n++) begin
      logic [AW-1:0] ia, na, qa;
      logic ib, suc, r;
      ia  = AW'($urandom_range(1, 14) * 4);
      na  = AW'($urandom_range(0, 1023) * 4);
      qa  = ($urandom_range(0, 3) == 0) ? ia : AW'($urandom_range(1, 14) * 4);
      ib  = ($urandom_range(0, 2) != 0);
      suc = ($urandom_range(0, 2) != 0);
      r   = ($urandom_range(0, 299) == 0);
      cyc(r, ib, suc, ia, na, qa, 1'b1);
    end

    cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left in scoreboard, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
